// File: rtl/student_fir_pkg.sv
// Shared types and default widths for the FIR slice sample path.
package student_fir_pkg;

    localparam int SAMPLE_ADDR_W = 10;
    localparam int SAMPLE_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } sample_rd_state_e;

endpackage

// File: rtl/student_sample_reader.sv
// Ring-buffer controller: writes each sample to the sample RAM, then streams the newest NumTaps back newest-first.
// Optional STUDENT_SAMPLE_CLEAR_EN zero-fills the whole ring after reset before accepting samples.
module student_sample_reader
    import student_fir_pkg::*;
#(
    parameter int AddrWidth = SAMPLE_ADDR_W,
    parameter int DataSize  = SAMPLE_DATA_W,
    parameter int NumTaps   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic [DataSize-1:0]  sample_i,
    output logic                 ram_ena_o,
    output logic                 ram_wea_o,
    output logic [AddrWidth-1:0] ram_addra_o,
    output logic [DataSize-1:0]  ram_dia_o,
    output logic                 ram_enb_o,
    output logic [AddrWidth-1:0] ram_addrb_o,
    input  logic [DataSize-1:0]  ram_dob_i,
    output logic                 tap_valid_o,
    output logic [AddrWidth-1:0] tap_idx_o,
    output logic                 tap_last_o,
    output logic [DataSize-1:0]  tap_data_o,
    output logic                 busy_o
);

    localparam logic [AddrWidth-1:0] LastK   = AddrWidth'(NumTaps - 1);
    localparam logic [AddrWidth-1:0] AddrMax = '1;

    if (NumTaps < 1 || NumTaps > (1 << AddrWidth)) begin : g_bad_num_taps
        $error("NumTaps must lie in 1 .. 2**AddrWidth");
    end

    sample_rd_state_e state_q, state_d;
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [AddrWidth-1:0] k_q, k_d;

    logic                 ready_c;
    logic                 ena_c;
    logic [AddrWidth-1:0] addra_c;
    logic [DataSize-1:0]  dia_c;
    logic                 rd_issue_c;
    logic [AddrWidth-1:0] addrb_c;

    logic                 tap_valid_p1;
    logic                 tap_last_p1;
    logic [AddrWidth-1:0] tap_idx_p1;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        k_d        = k_q;
        ready_c    = 1'b0;
        ena_c      = 1'b0;
        addra_c    = wr_ptr_q;
        dia_c      = '0;
        rd_issue_c = 1'b0;
        addrb_c    = base_q - k_q;

        case (state_q)
`ifdef STUDENT_SAMPLE_CLEAR_EN
            // The write pointer doubles as the clear address and wraps back to 0 on exit.
            ST_CLEAR: begin
                ena_c    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == AddrMax) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                ready_c = 1'b1;
                if (sample_valid_i) begin
                    ena_c    = 1'b1;
                    dia_c    = sample_i;
                    base_d   = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    k_d      = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                rd_issue_c = 1'b1;
                k_d        = k_q + 1'b1;
                if (k_q == LastK) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // p0 -> p1: tap sideband registered so it lines up with the RAM read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef STUDENT_SAMPLE_CLEAR_EN
            state_q <= ST_CLEAR;
`else
            state_q <= ST_IDLE;
`endif
            wr_ptr_q     <= '0;
            base_q       <= '0;
            k_q          <= '0;
            tap_valid_p1 <= 1'b0;
            tap_last_p1  <= 1'b0;
            tap_idx_p1   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            k_q          <= k_d;
            tap_valid_p1 <= rd_issue_c;
            tap_last_p1  <= rd_issue_c && (k_q == LastK);
            tap_idx_p1   <= k_q;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign sample_ready_o = ready_c && !rst_i;
    assign ram_ena_o      = ena_c && !rst_i;
    assign ram_wea_o      = ram_ena_o;
    assign ram_addra_o    = rst_i ? '0 : addra_c;
    assign ram_dia_o      = rst_i ? '0 : dia_c;
    assign ram_enb_o      = rd_issue_c && !rst_i;
    assign ram_addrb_o    = rst_i ? '0 : addrb_c;
    assign busy_o         = (state_q != ST_IDLE) && !rst_i;

    assign tap_valid_o = tap_valid_p1;
    assign tap_idx_o   = tap_idx_p1;
    assign tap_last_o  = tap_last_p1;
    assign tap_data_o  = ram_dob_i;

endmodule

// File: tb/tb_student_sample_reader.sv
// Directed bench for student_sample_reader: AddrWidth=3 with NumTaps=4 and NumTaps=8 instances, each with a RAM model.
module tb_student_sample_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // NumTaps = 4 instance
    logic        vld = 1'b0, rdy, ena, wea, enb, tv, last, busy;
    logic [15:0] smp = 16'h0, dia, dob, tdata;
    logic [2:0]  addra, addrb, idx;
    logic [15:0] mem [8] = '{default: 16'h0};

    student_sample_reader #(.AddrWidth(3), .DataSize(16), .NumTaps(4)) dut (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(vld), .sample_ready_o(rdy), .sample_i(smp),
        .ram_ena_o(ena), .ram_wea_o(wea), .ram_addra_o(addra), .ram_dia_o(dia),
        .ram_enb_o(enb), .ram_addrb_o(addrb), .ram_dob_i(dob),
        .tap_valid_o(tv), .tap_idx_o(idx), .tap_last_o(last), .tap_data_o(tdata), .busy_o(busy)
    );

    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) dob <= mem[addrb];
    end

    // NumTaps = 8 (full depth) instance
    logic        vld8 = 1'b0, rdy8, ena8, wea8, enb8, tv8, last8, busy8;
    logic [15:0] smp8 = 16'h0, dia8, dob8, tdata8;
    logic [2:0]  addra8, addrb8, idx8;
    logic [15:0] mem8 [8] = '{default: 16'h0};

    student_sample_reader #(.AddrWidth(3), .DataSize(16), .NumTaps(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(vld8), .sample_ready_o(rdy8), .sample_i(smp8),
        .ram_ena_o(ena8), .ram_wea_o(wea8), .ram_addra_o(addra8), .ram_dia_o(dia8),
        .ram_enb_o(enb8), .ram_addrb_o(addrb8), .ram_dob_i(dob8),
        .tap_valid_o(tv8), .tap_idx_o(idx8), .tap_last_o(last8), .tap_data_o(tdata8), .busy_o(busy8)
    );

    always @(posedge clk) begin
        if (ena8 && wea8) mem8[addra8] <= dia8;
        if (enb8) dob8 <= mem8[addrb8];
    end

    typedef struct {
        logic        vld;
        logic [15:0] smp;
        logic        rdy;
        logic        ena;
        logic [2:0]  addra;
        logic        enb;
        logic [2:0]  addrb;
        logic        tv;
        logic [2:0]  idx;
        logic        last;
        logic        busy;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        vld8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first READ cycle with valid dropped.
    task automatic send(input logic [15:0] d, output logic [2:0] a);
        int n;
        n = 0;
        vld = 1'b1;
        smp = d;
        #1;
        while (!rdy && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_within_bound", 32'(n < 40), 32'd1);
        a = addra;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic collect4(input logic [2:0] base, input logic [15:0] exp [4]);
        for (int j = 0; j < 6; j++) begin
            logic [2:0] ea;
            ea = base - 3'(j);
            #1;
            check("ready_after_seq", 32'(rdy), 32'(j == 5));
            check("enb", 32'(enb), 32'(j < 4));
            if (j < 4) check("addrb", 32'(addrb), 32'(ea));
            check("tap_valid", 32'(tv), 32'(j >= 1 && j <= 4));
            if (j >= 1 && j <= 4) begin
                check("tap_idx", 32'(idx), 32'(j - 1));
                check("tap_data", 32'(tdata), 32'(exp[j-1]));
            end
            check("tap_last", 32'(last), 32'(j == 4));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0]  a;
        logic [15:0] exp4 [4];
        int          accepts, gap_bad, viol, last_acc, cnt, n;

        // vld smp rdy ena addra enb addrb tv idx last busy data
        tbl[0] = '{1'b1, 16'h0011, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0011};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 3'd1, 1'b0, 1'b1, 16'h0000};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0000};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b1, 16'h0000};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_ena", 32'(ena), 32'd0);
        check("rst_enb", 32'(enb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tap_valid", 32'(tv), 32'd0);
        check("rst_tap_last", 32'(last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef STUDENT_SAMPLE_CLEAR_EN
        for (int c = 0; c < 8; c++) begin
            #1;
            check("clr_ena", 32'(ena && wea), 32'd1);
            check("clr_addra", 32'(addra), 32'(c));
            check("clr_dia", 32'(dia), 32'd0);
            check("clr_ready", 32'(rdy), 32'd0);
            check("clr_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
`endif

        // Single sample, table-driven cycle by cycle
        for (int v = 0; v < 7; v++) begin
            vld = tbl[v].vld;
            smp = tbl[v].smp;
            #1;
            check("t1_ready", 32'(rdy), 32'(tbl[v].rdy));
            check("t1_ena", 32'(ena), 32'(tbl[v].ena));
            check("t1_wea", 32'(wea), 32'(tbl[v].ena));
            if (tbl[v].ena) begin
                check("t1_addra", 32'(addra), 32'(tbl[v].addra));
                check("t1_dia", 32'(dia), 32'(tbl[v].smp));
            end
            check("t1_enb", 32'(enb), 32'(tbl[v].enb));
            if (tbl[v].enb) check("t1_addrb", 32'(addrb), 32'(tbl[v].addrb));
            check("t1_tap_valid", 32'(tv), 32'(tbl[v].tv));
            if (tbl[v].tv) begin
                check("t1_tap_idx", 32'(idx), 32'(tbl[v].idx));
                check("t1_tap_data", 32'(tdata), 32'(tbl[v].data));
            end
            check("t1_tap_last", 32'(last), 32'(tbl[v].last));
            check("t1_busy", 32'(busy), 32'(tbl[v].busy));
            @(negedge clk);
        end

        // Samples 1..10 back to back: write pointer wraps 7->0, reads wrap below 0
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            send(16'(i), a);
            check("t2_wr_addr", 32'(a), 32'((i - 1) % 8));
            if (i < 10) begin
                repeat (5) @(negedge clk);
            end
        end
        exp4 = '{16'd10, 16'd9, 16'd8, 16'd7};
        collect4(3'd1, exp4);

        // Valid held high: one accept per 6 cycles, ready never with busy
        accepts = 0;
        gap_bad = 0;
        viol = 0;
        last_acc = -6;
        vld = 1'b1;
        for (int c = 0; c < 30; c++) begin
            smp = 16'(16'h0100 + c);
            #1;
            if (rdy && vld) begin
                accepts++;
                if (c - last_acc != 6) gap_bad++;
                last_acc = c;
            end
            if (rdy && busy) viol++;
            @(negedge clk);
        end
        vld = 1'b0;
        check("t3_accepts", 32'(accepts), 32'd5);
        check("t3_accept_spacing", 32'(gap_bad), 32'd0);
        check("t3_ready_while_busy", 32'(viol), 32'd0);

        // Reset during the second tap aborts the sequence
        do_reset();
        send(16'h0011, a);
        check("t4_wr_addr", 32'(a), 32'd0);
        @(negedge clk);
        #1;
        check("t4_tap0_valid", 32'(tv), 32'd1);
        check("t4_tap0_idx", 32'(idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_tap1_valid", 32'(tv), 32'd1);
        check("t4_tap1_idx", 32'(idx), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_valid_after_rst", 32'(tv), 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (tv || last) cnt++;
        end
        check("t4_no_taps_after_rst", 32'(cnt), 32'd0);
        @(negedge clk);
        send(16'h0055, a);
        check("t4_next_wr_addr", 32'(a), 32'd0);
        repeat (5) @(negedge clk);

        // Full-depth instance: after samples 1..9, taps are 9..2
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            n = 0;
            vld8 = 1'b1;
            smp8 = 16'(i);
            #1;
            while (!rdy8 && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("t6_accept_within_bound", 32'(n < 60), 32'd1);
            @(negedge clk);
            vld8 = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            #1;
            check("t6_tap_valid", 32'(tv8), 32'(j >= 1 && j <= 8));
            if (j >= 1 && j <= 8) begin
                check("t6_tap_idx", 32'(idx8), 32'(j - 1));
                check("t6_tap_data", 32'(tdata8), 32'(10 - j));
            end
            check("t6_tap_last", 32'(last8), 32'(j == 8));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
